ps2_rx: RTL and testbench

Receives PS/2 keyboard frames and decodes them into key events. It sits directly downstream of the clock-synchronisation stage and consumes its synchronised keyboard clock `keyClk2` together with the raw keyboard data line. It assembles each 11-bit frame (start, 8 data bits LSB-first, odd parity, stop) into a scan byte. It then folds the E0 (extended) and F0 (release) prefixes into single key events for the game and display logic.

---
 rtl/ps2_rx.sv | 173 +++++++++++++++++
 tb/tb_ps2_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frames 11-bit serial words into scan bytes
// and folds E0/F0 prefixes into single key events.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       keyClk2,
    input  logic       keyData,
    output logic [7:0] scanByte,
    output logic       byteValid,
    output logic       frameErr,
    output logic [7:0] keyCode,
    output logic       released,
    output logic       extended,
    output logic       keyValid
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          data_meta;
    logic          data_sync;
    logic          prev_clk;
    logic          fall;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic [3:0]    bit_cnt;
    logic [3:0]    bit_cnt_next;
    logic          parity_bit;
    logic          parity_next;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_next;
    logic          abort;
    logic          load_byte;
    logic          err_set;
    logic          ext_pend;
    logic          rel_pend;

    assign fall  = prev_clk & ~keyClk2;
    assign abort = (state != IDLE) && !fall && (to_cnt == TO_MAX);

    // Data line is asynchronous to sysClk; idle level is high.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            prev_clk  <= 1'b1;
        end else begin
            data_meta <= keyData;
            data_sync <= data_meta;
            prev_clk  <= keyClk2;
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        load_byte    = 1'b0;
        err_set      = 1'b0;
        if (abort) begin
            state_next   = IDLE;
            shift_next   = 8'h00;
            bit_cnt_next = 4'd0;
            err_set      = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!data_sync) begin
                        state_next   = DATA;
                        bit_cnt_next = 4'd0;
                    end
                end
                DATA: begin
                    shift_next   = {data_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = data_sync;
                    state_next  = STOP;
                end
                STOP: begin
                    if (data_sync && ((^shift_reg) ^ parity_bit)) begin
                        load_byte = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        to_next = to_cnt;
        if (state == IDLE || fall || abort) begin
            to_next = '0;
        end else if (to_cnt != '1) begin
            to_next = to_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= 8'h00;
            bit_cnt    <= 4'd0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            scanByte   <= 8'h00;
            byteValid  <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
            parity_bit <= parity_next;
            to_cnt     <= to_next;
            byteValid  <= load_byte;
            frameErr   <= err_set;
            if (load_byte) begin
                scanByte <= shift_reg;
            end
        end
    end

    // Prefix folding runs one cycle behind the framer.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
            keyCode  <= 8'h00;
            released <= 1'b0;
            extended <= 1'b0;
            keyValid <= 1'b0;
        end else begin
            keyValid <= 1'b0;
            if (byteValid) begin
                unique case (scanByte)
                    8'hE0: ext_pend <= 1'b1;
                    8'hF0: rel_pend <= 1'b1;
                    default: begin
                        keyCode  <= scanByte;
                        released <= rel_pend;
                        extended <= ext_pend;
                        keyValid <= 1'b1;
                        ext_pend <= 1'b0;
                        rel_pend <= 1'b0;
                    end
                endcase
            end else if (frameErr) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: framing, prefixes, errors, timeout, reset.
module tb_ps2_rx;

    logic       sysClk = 1'b0;
    logic       reset = 1'b1;
    logic       keyClk2 = 1'b1;
    logic       keyData = 1'b1;
    logic [7:0] scanByte;
    logic       byteValid;
    logic       frameErr;
    logic [7:0] keyCode;
    logic       released;
    logic       extended;
    logic       keyValid;

    int checks = 0;
    int errors = 0;
    int bv_n = 0;
    int fe_n = 0;
    int kv_n = 0;
    int overlap_n = 0;
    int long_n = 0;
    int kv_lat_bad = 0;
    logic prev_bv = 1'b0;
    logic prev_fe = 1'b0;
    logic prev_kv = 1'b0;

    ps2_rx #(.TIMEOUT_CYCLES(50)) dut (
        .sysClk(sysClk),
        .reset(reset),
        .keyClk2(keyClk2),
        .keyData(keyData),
        .scanByte(scanByte),
        .byteValid(byteValid),
        .frameErr(frameErr),
        .keyCode(keyCode),
        .released(released),
        .extended(extended),
        .keyValid(keyValid)
    );

    always #5 sysClk = ~sysClk;

    always @(negedge sysClk) begin
        if (byteValid) bv_n++;
        if (frameErr) fe_n++;
        if (keyValid) kv_n++;
        if (byteValid && frameErr) overlap_n++;
        if ((byteValid && prev_bv) || (frameErr && prev_fe)
            || (keyValid && prev_kv)) long_n++;
        if (keyValid && !prev_bv) kv_lat_bad++;
        prev_bv = byteValid;
        prev_fe = frameErr;
        prev_kv = keyValid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    task automatic send_bit(input logic b);
        keyData = b;
        wait_cycles(5);
        keyClk2 = 1'b0;
        wait_cycles(10);
        keyClk2 = 1'b1;
        wait_cycles(5);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        keyData = 1'b1;
        wait_cycles(20);
    endtask

    task automatic good_frame(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
        checks++;
        if ({scanByte, keyCode} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bytes: got %h/%h want 00/00", scanByte, keyCode);
        end
        checks++;
        if ({byteValid, frameErr, keyValid, released, extended} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {byteValid, frameErr, keyValid, released, extended});
        end
    endtask

    task automatic test_make_1c;
        int b0, k0;
        b0 = bv_n; k0 = kv_n;
        good_frame(8'h1C);
        checks++;
        if (bv_n - b0 !== 1 || scanByte !== 8'h1C) begin
            errors++;
            $display("FAIL make_byte: got n=%0d byte=%h want 1/1c", bv_n - b0, scanByte);
        end
        checks++;
        if (kv_n - k0 !== 1 || {keyCode, released, extended} !== {8'h1C, 2'b00}) begin
            errors++;
            $display("FAIL make_key: got n=%0d %h r=%b e=%b want 1 1c 0 0",
                     kv_n - k0, keyCode, released, extended);
        end
    endtask

    task automatic test_release;
        int k0;
        k0 = kv_n;
        good_frame(8'hF0);
        checks++;
        if (kv_n - k0 !== 0) begin
            errors++;
            $display("FAIL rel_prefix: got %0d keyValid want 0", kv_n - k0);
        end
        good_frame(8'h1C);
        checks++;
        if (kv_n - k0 !== 1 || {keyCode, released, extended} !== {8'h1C, 2'b10}) begin
            errors++;
            $display("FAIL rel_key: got n=%0d %h r=%b e=%b want 1 1c 1 0",
                     kv_n - k0, keyCode, released, extended);
        end
    endtask

    task automatic test_ext_release;
        int k0;
        k0 = kv_n;
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h75);
        checks++;
        if (kv_n - k0 !== 1 || {keyCode, released, extended} !== {8'h75, 2'b11}) begin
            errors++;
            $display("FAIL ext_rel: got n=%0d %h r=%b e=%b want 1 75 1 1",
                     kv_n - k0, keyCode, released, extended);
        end
    endtask

    task automatic test_parity_err;
        int b0, f0, k0;
        b0 = bv_n; f0 = fe_n; k0 = kv_n;
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++;
        if (fe_n - f0 !== 1 || bv_n - b0 !== 0 || kv_n - k0 !== 0) begin
            errors++;
            $display("FAIL parity_err: got fe=%0d bv=%0d kv=%0d want 1 0 0",
                     fe_n - f0, bv_n - b0, kv_n - k0);
        end
        checks++;
        if (scanByte !== 8'h75) begin
            errors++;
            $display("FAIL parity_hold: got %h want 75", scanByte);
        end
    endtask

    task automatic test_stop_err;
        int f0, k0;
        f0 = fe_n; k0 = kv_n;
        good_frame(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b0);
        good_frame(8'h1C);
        checks++;
        if (fe_n - f0 !== 1) begin
            errors++;
            $display("FAIL stop_err: got fe=%0d want 1", fe_n - f0);
        end
        checks++;
        if (kv_n - k0 !== 1 || {keyCode, released, extended} !== {8'h1C, 2'b00}) begin
            errors++;
            $display("FAIL stop_clear: got n=%0d %h r=%b e=%b want 1 1c 0 0",
                     kv_n - k0, keyCode, released, extended);
        end
    endtask

    task automatic test_timeout;
        int b0, f0, k0;
        logic [7:0] d;
        b0 = bv_n; f0 = fe_n;
        d = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        keyData = 1'b1;
        wait_cycles(80);
        checks++;
        if (fe_n - f0 !== 1 || bv_n - b0 !== 0) begin
            errors++;
            $display("FAIL timeout: got fe=%0d bv=%0d want 1 0", fe_n - f0, bv_n - b0);
        end
        k0 = kv_n;
        good_frame(8'h29);
        checks++;
        if (kv_n - k0 !== 1 || {keyCode, released, extended} !== {8'h29, 2'b00}) begin
            errors++;
            $display("FAIL timeout_next: got n=%0d %h r=%b e=%b want 1 29 0 0",
                     kv_n - k0, keyCode, released, extended);
        end
    endtask

    task automatic test_idle_glitch;
        int b0, f0;
        b0 = bv_n; f0 = fe_n;
        send_bit(1'b1);
        wait_cycles(80);
        checks++;
        if (fe_n - f0 !== 0 || bv_n - b0 !== 0) begin
            errors++;
            $display("FAIL idle_high: got fe=%0d bv=%0d want 0 0", fe_n - f0, bv_n - b0);
        end
    endtask

    task automatic test_back_to_back;
        int k0;
        k0 = kv_n;
        good_frame(8'hE0);
        good_frame(8'h75);
        checks++;
        if (kv_n - k0 !== 1 || {keyCode, released, extended} !== {8'h75, 2'b01}) begin
            errors++;
            $display("FAIL ext_make: got n=%0d %h r=%b e=%b want 1 75 0 1",
                     kv_n - k0, keyCode, released, extended);
        end
        good_frame(8'h00);
        checks++;
        if (kv_n - k0 !== 2 || {keyCode, scanByte, extended} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL zero_key: got n=%0d %h/%h e=%b want 2 00/00 0",
                     kv_n - k0, keyCode, scanByte, extended);
        end
        good_frame(8'hFF);
        checks++;
        if (kv_n - k0 !== 3 || keyCode !== 8'hFF) begin
            errors++;
            $display("FAIL ff_key: got n=%0d %h want 3 ff", kv_n - k0, keyCode);
        end
    endtask

    task automatic test_reset_mid;
        int b0, f0, k0;
        logic [7:0] d;
        d = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        b0 = bv_n; f0 = fe_n; k0 = kv_n;
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(1);
        checks++;
        if ({scanByte, keyCode, byteValid, frameErr, keyValid, released, extended}
            !== 21'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h %h %b want 00 00 00000", scanByte, keyCode,
                     {byteValid, frameErr, keyValid, released, extended});
        end
        wait_cycles(80);
        checks++;
        if (fe_n - f0 !== 0 || bv_n - b0 !== 0 || kv_n - k0 !== 0) begin
            errors++;
            $display("FAIL reset_quiet: got fe=%0d bv=%0d kv=%0d want 0 0 0",
                     fe_n - f0, bv_n - b0, kv_n - k0);
        end
        good_frame(8'h1C);
        checks++;
        if (kv_n - k0 !== 1 || {keyCode, released, extended} !== {8'h1C, 2'b00}) begin
            errors++;
            $display("FAIL reset_next: got n=%0d %h r=%b e=%b want 1 1c 0 0",
                     kv_n - k0, keyCode, released, extended);
        end
    endtask

    task automatic test_pulse_rules;
        checks++;
        if (overlap_n !== 0 || long_n !== 0 || kv_lat_bad !== 0) begin
            errors++;
            $display("FAIL pulse_rules: got overlap=%0d long=%0d kvlat=%0d want 0 0 0",
                     overlap_n, long_n, kv_lat_bad);
        end
    endtask

    initial begin
        test_reset;
        test_make_1c;
        test_release;
        test_ext_release;
        test_parity_err;
        test_stop_err;
        test_timeout;
        test_idle_glitch;
        test_back_to_back;
        test_reset_mid;
        test_pulse_rules;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
